// File: rtl/rv32imf_wb_arbiter.sv
// Writeback arbiter for the two register-file write ports.
// Port A carries registered execute results. Port B merges load results with
// multi-cycle results. Multi-cycle results are buffered in a small FIFO, and a
// load that arrives in the same cycle wins over the FIFO.
module rv32imf_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ex_we_i,
    input  logic [ADDR_WIDTH-1:0]        ex_waddr_i,
    input  logic [DATA_WIDTH-1:0]        ex_wdata_i,
    input  logic                         lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0]        lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]        lsu_wdata_i,
    input  logic                         mc_valid_i,
    output logic                         mc_ready_o,
    input  logic [ADDR_WIDTH-1:0]        mc_waddr_i,
    input  logic [DATA_WIDTH-1:0]        mc_wdata_i,
    output logic                         we_a_o,
    output logic [ADDR_WIDTH-1:0]        waddr_a_o,
    output logic [DATA_WIDTH-1:0]        wdata_a_o,
    output logic                         we_b_o,
    output logic [ADDR_WIDTH-1:0]        waddr_b_o,
    output logic [DATA_WIDTH-1:0]        wdata_b_o,
    output logic [(2**ADDR_WIDTH)-1:0]   pending_o,
    output logic [$clog2(DEPTH):0]       fifo_count_o
);

    localparam int unsigned PtrWidth = $clog2(DEPTH);
    localparam int unsigned CntWidth = PtrWidth + 1;
    localparam logic [CntWidth-1:0] CountFull = CntWidth'(DEPTH);

    // FIFO storage; the write flag is cleared for x0 destinations
    logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [DEPTH-1:0]      r_mem_we;

    logic [PtrWidth-1:0]   r_wr_ptr;
    logic [PtrWidth-1:0]   r_rd_ptr;
    logic [CntWidth-1:0]   r_count;

    logic                  r_we_a;
    logic [ADDR_WIDTH-1:0] r_waddr_a;
    logic [DATA_WIDTH-1:0] r_wdata_a;
    logic                  r_we_b;
    logic [ADDR_WIDTH-1:0] r_waddr_b;
    logic [DATA_WIDTH-1:0] r_wdata_b;

    logic                      w_push;
    logic                      w_pop;
    logic [DEPTH-1:0]          w_entry_valid;
    logic [(2**ADDR_WIDTH)-1:0] w_pending;

    // No pass-through: a pop in a full cycle does not open the FIFO for a push
    assign mc_ready_o = !rst && (r_count < CountFull);
    assign w_push     = mc_valid_i && mc_ready_o;
    assign w_pop      = !lsu_valid_i && (r_count != '0);

    // Port A: registered execute result with x0 filter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we_a    <= 1'b0;
            r_waddr_a <= '0;
            r_wdata_a <= '0;
        end else begin
            r_we_a    <= ex_we_i && (ex_waddr_i != '0);
            r_waddr_a <= ex_waddr_i;
            r_wdata_a <= ex_wdata_i;
        end
    end

    // FIFO entry write on push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= mc_waddr_i;
            r_mem_data[r_wr_ptr] <= mc_wdata_i;
            r_mem_we[r_wr_ptr]   <= (mc_waddr_i != '0);
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CntWidth'(w_push) - CntWidth'(w_pop);
        end
    end

    // Port B: load result first, otherwise FIFO head, otherwise idle.
    // Address/data hold their last value while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we_b    <= 1'b0;
            r_waddr_b <= '0;
            r_wdata_b <= '0;
        end else if (lsu_valid_i) begin
            r_we_b    <= (lsu_waddr_i != '0);
            r_waddr_b <= lsu_waddr_i;
            r_wdata_b <= lsu_wdata_i;
        end else if (w_pop) begin
            r_we_b    <= r_mem_we[r_rd_ptr];
            r_waddr_b <= r_mem_addr[r_rd_ptr];
            r_wdata_b <= r_mem_data[r_rd_ptr];
        end else begin
            r_we_b    <= 1'b0;
        end
    end

    // Entry i is live when its distance from the read pointer is below count
    always_comb begin
        w_entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_entry_valid[i] = ({1'b0, PtrWidth'(i) - r_rd_ptr} < r_count);
        end
    end

    // Outstanding writes: live flagged FIFO entries plus the port B write
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i] && r_mem_we[i]) w_pending[r_mem_addr[i]] = 1'b1;
        end
        if (r_we_b) w_pending[r_waddr_b] = 1'b1;
        w_pending[0] = 1'b0;
    end

    assign we_a_o       = r_we_a;
    assign waddr_a_o    = r_waddr_a;
    assign wdata_a_o    = r_wdata_a;
    assign we_b_o       = r_we_b;
    assign waddr_b_o    = r_waddr_b;
    assign wdata_b_o    = r_wdata_b;
    assign pending_o    = w_pending;
    assign fifo_count_o = r_count;

endmodule
